// File: rtl/mips_bus_if.sv
// mips_bus_if: word-aligned memory bus between the bus master and its responder.
interface mips_bus_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  modport master(output address, read, write, byteenable, writedata, input waitrequest, readdata);
  modport slave(input address, read, write, byteenable, writedata, output waitrequest, readdata);
endinterface

// File: rtl/mips_bus_master.sv
// mips_bus_master: runs one core load/store at a time on the word bus with lane steering,
// load extension, misalignment trapping and an optional stall timeout.
module mips_bus_master #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_err_o,
  mips_bus_if.master  bus
);
  typedef enum logic [1:0] {IDLE, BUS, RDATA, ERR} state_t;
  state_t      state_q, state_d;
  logic        read_q, read_d, write_q, write_d, sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, cnt_q, cnt_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d, lane_q, lane_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_err_q, resp_err_d;
  logic        misalign;
  logic [3:0]  be_new;
  logic [31:0] wd_new, ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  always_comb begin
    misalign = (req_size_i == 2'b01 & req_addr_i[0]) | (req_size_i == 2'b10 & |req_addr_i[1:0]) | (req_size_i == 2'b11);
    be_new = req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0] : req_size_i == 2'b01 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_new = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} : req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    rbyte = bus.readdata[{lane_q, 3'b000} +: 8];
    rhalf = bus.readdata[{lane_q[1], 4'b0000} +: 16];
    ext = size_q == 2'b00 ? {{24{sgn_q & rbyte[7]}}, rbyte} : size_q == 2'b01 ? {{16{sgn_q & rhalf[15]}}, rhalf} : bus.readdata;
  end
  always_comb begin
    state_d = state_q;
    read_d = read_q;
    write_d = write_q;
    addr_d = addr_q;
    be_d = be_q;
    wd_d = wd_q;
    size_d = size_q;
    sgn_d = sgn_q;
    lane_d = lane_q;
    cnt_d = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d = 2'b00;
    case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d = {req_addr_i[31:2], 2'b00};
        size_d = req_size_i;
        sgn_d = req_signed_i;
        lane_d = req_addr_i[1:0];
        be_d = be_new;
        wd_d = wd_new;
        cnt_d = 32'd0;
        read_d = ~misalign & ~req_write_i;
        write_d = ~misalign & req_write_i;
        state_d = misalign ? ERR : BUS;
      end
      BUS: if (!bus.waitrequest) begin
        read_d = 1'b0;
        write_d = 1'b0;
        resp_valid_d = write_q;
        state_d = read_q ? RDATA : IDLE;
      end else begin
        cnt_d = cnt_q + 32'd1;
        // abandon the transfer once the stall count hits the limit
        if (TIMEOUT != 0 && cnt_d == TIMEOUT) begin
          read_d = 1'b0;
          write_d = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d = 2'b10;
          state_d = IDLE;
        end
      end
      RDATA: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ext;
        state_d = IDLE;
      end
      ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d = 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      read_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= 32'd0;
      be_q <= 4'd0;
      wd_q <= 32'd0;
      size_q <= 2'b00;
      sgn_q <= 1'b0;
      lane_q <= 2'b00;
      cnt_q <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q <= 2'b00;
    end else begin
      state_q <= state_d;
      read_q <= read_d;
      write_q <= write_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wd_q <= wd_d;
      size_q <= size_d;
      sgn_q <= sgn_d;
      lane_q <= lane_d;
      cnt_q <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o = resp_err_q;
  assign bus.address = addr_q;
  assign bus.read = read_q;
  assign bus.write = write_q;
  assign bus.byteenable = be_q;
  assign bus.writedata = wd_q;
endmodule

// File: tb/tb_mips_bus_master.sv
// tb_mips_bus_master: random and directed loads/stores against a byte-addressed memory model.
module tb_mips_bus_master;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  mips_bus_if bus_if();
  mips_bus_master #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_signed_i(req_signed),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .bus(bus_if)
  );
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int stalls = 0, stall_n = 0;
  bit stuck = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [31:0] last_rdata;
  logic [1:0]  last_err;
  // responder: stalls stall_n edges per strobe (or forever when stuck), returns data one cycle after accept
  assign bus_if.waitrequest = stuck || ((bus_if.read || bus_if.write) && stalls < stall_n);
  always @(posedge clk) begin
    if (reset) begin
      stalls <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (bus_if.read || bus_if.write) begin
      if (bus_if.waitrequest) stalls <= stalls + 1;
      else begin
        stalls <= 0;
        for (int i = 0; i < 4; i++)
          if (bus_if.write && bus_if.byteenable[i]) mem[8'(bus_if.address[7:0] + 8'(i))] <= bus_if.writedata[8*i +: 8];
        if (bus_if.read)
          bus_if.readdata <= {mem[8'(bus_if.address[7:0] + 8'd3)], mem[8'(bus_if.address[7:0] + 8'd2)],
                              mem[8'(bus_if.address[7:0] + 8'd1)], mem[bus_if.address[7:0]]};
      end
    end else stalls <= 0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input bit wr, input logic [31:0] a, input logic [1:0] sz, input bit sg,
                     input logic [31:0] wd, input int st);
    int nb, lane, exp_n, exp_strb, got_n, strb;
    bit mis;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd, got_rd;
    logic [1:0]  eerr, got_err;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    lane = int'(a % 4);
    mis = sz == 2'd3 || (a % nb != 0);
    ebe = 4'd0;
    for (int i = 0; i < 4; i++) if (i >= lane && i < lane + nb) ebe[i] = 1'b1;
    ewd = sz == 2'd0 ? {4{wd[7:0]}} : sz == 2'd1 ? {2{wd[15:0]}} : wd;
    erd = 32'd0;
    if (!wr && !mis) begin
      for (int i = 0; i < nb; i++) erd = erd | (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
      if (sg && erd[8*nb-1]) for (int i = 8 * nb; i < 32; i++) erd[i] = 1'b1;
    end
    eerr = mis ? 2'd1 : 2'd0;
    exp_strb = mis ? 0 : st + 1;
    exp_n = mis ? 2 : wr ? st + 2 : st + 3;
    if (stuck && !mis) begin
      eerr = 2'd2; erd = 32'd0; exp_strb = 4; exp_n = 5;
    end
    stall_n = st;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got_n = 0; strb = 0; got_rd = 32'd0; got_err = 2'd0;
    for (int n = 1; n <= 20 && got_n == 0; n++) begin
      @(negedge clk);
      if (bus_if.read || bus_if.write) begin
        strb++;
        check("strobe", 32'({bus_if.read, bus_if.write}), wr ? 32'd1 : 32'd2);
        check("address", bus_if.address, {a[31:2], 2'b00});
        check("byteenable", 32'(bus_if.byteenable), 32'(ebe));
        if (wr) check("writedata", bus_if.writedata, ewd);
      end
      if (resp_valid) begin
        got_n = n; got_rd = resp_rdata; got_err = resp_err;
        check("ready_resp", 32'(req_ready), 32'd1);
      end
    end
    check("latency", 32'(got_n), 32'(exp_n));
    check("strobes", 32'(strb), 32'(exp_strb));
    check("rdata", got_rd, erd);
    check("err", 32'(got_err), 32'(eerr));
    @(negedge clk);
    check("pulse_one", 32'(resp_valid), 32'd0);
    if (wr && !mis && !stuck)
      for (int i = 0; i < nb; i++) begin
        ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
        check("mem", 32'(mem[8'(a + 32'(i))]), 32'(wd[8*i +: 8]));
      end
    last_rdata = got_rd;
    last_err = got_err;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16] = 8'h78; ref_mem[17] = 8'h56; ref_mem[18] = 8'h34; ref_mem[19] = 8'h12;
    #1 reset = 1'b1;
    #1;
    check("rst_read", 32'(bus_if.read), 32'd0);
    check("rst_write", 32'(bus_if.write), 32'd0);
    check("rst_address", bus_if.address, 32'd0);
    check("rst_be", 32'(bus_if.byteenable), 32'd0);
    check("rst_wdata", bus_if.writedata, 32'd0);
    check("rst_resp", {29'd0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0);
    check("word_load", last_rdata, 32'h12345678);
    run(1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080, 0);
    run(1'b0, 32'h13, 2'd0, 1'b1, 32'd0, 0);
    check("sbyte_load", last_rdata, 32'hFFFFFF80);
    run(1'b0, 32'h13, 2'd0, 1'b0, 32'd0, 0);
    check("ubyte_load", last_rdata, 32'h00000080);
    run(1'b1, 32'h22, 2'd1, 1'b0, 32'h0000BEEF, 3);
    check("half_store", {16'd0, mem[8'h23], mem[8'h22]}, 32'h0000BEEF);
    run(1'b0, 32'h06, 2'd2, 1'b0, 32'd0, 0);
    check("misaligned_err", 32'(last_err), 32'd1);
    stuck = 1'b1;
    run(1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 0);
    stuck = 1'b0;
    check("timeout_err", 32'(last_err), 32'd2);
    run(1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 1);
    for (int k = 0; k < 40; k++)
      run(1'($urandom), {24'd0, 8'($urandom)}, 2'($urandom_range(0, 3)), 1'($urandom),
          $urandom, int'($urandom_range(0, 3)));
    stuck = 1'b1;
    stall_n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_size = 2'd2; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stalled_write", 32'(bus_if.write), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_write", 32'(bus_if.write), 32'd0);
    check("async_read", 32'(bus_if.read), 32'd0);
    check("async_resp", 32'(resp_valid), 32'd0);
    stuck = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_resp", 32'(resp_valid), 32'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_resp", 32'(resp_valid), 32'd0);
      check("post_rst_write", 32'(bus_if.write), 32'd0);
    end
    check("post_rst_ready", 32'(req_ready), 32'd1);
    run(1'b0, 32'h80, 2'd2, 1'b0, 32'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_bus_master.md
# mips_bus_master

Bus initiator for the MIPS CPU memory interface: it takes one load or store request at a time from the core datapath and runs it on the shared bus. The bus uses word-aligned `address`, `read`/`write` strobes, `byteenable`, `waitrequest` stall, and 1-cycle `readdata`. The block generates byte lanes for byte, half and word accesses, extends load data, flags misaligned accesses, and can optionally abandon a stalled transfer. It sits between the core's memory stage and the top-level bus ports of `mips_cpu_bus`.

## Interface
- `TIMEOUT`, default 0: max cycles a strobe may be stalled by `waitrequest` before abort; 0 disables the timeout.
- `clk` in 1: the single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: equals (state == IDLE); the request is accepted on an edge where `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as misaligned.
- `req_signed` in 1: sign-extend when 1, zero-extend when 0 (loads only).
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 timeout.
- `address` out 32: `{req_addr[31:2], 2'b00}`.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `byteenable` out 4: active byte lanes.
- `writedata` out 32: lane-positioned store data.
- `waitrequest` in 1: responder stall.
- `readdata` in 32: valid in the cycle after the read is accepted.

## Operation
- States: IDLE, BUS, RDATA, ERR.
- IDLE, on accept:
  - Register address, size, signed and lane.
  - If misaligned, go to ERR. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Otherwise go to BUS and assert `read` or `write` (registered).
- Lanes are little-endian with lane = addr[1:0].
  - Byte: `byteenable` = 1<<lane; `writedata` = wdata[7:0] replicated to all 4 lanes.
  - Half: `byteenable` = 0011 (addr[1]=0) or 1100 (addr[1]=1); `writedata` = {wdata[15:0], wdata[15:0]}.
  - Word: `byteenable` = 1111; `writedata` = wdata.
- BUS: hold `address`, `byteenable`, `writedata` and the strobe constant while `waitrequest`=1. On an edge with `waitrequest`=0:
  - Store: drop `write`; pulse `resp_valid` with err 00; go to IDLE.
  - Load: drop `read`; go to RDATA.
- RDATA: on the next edge, capture `readdata`, select the lane(s), extend to 32 bits, pulse `resp_valid`, go to IDLE.
- ERR: on the next edge pulse `resp_valid` with err 01 and `resp_rdata` = 0, then go to IDLE. No bus strobe is ever issued for a misaligned access.
- Timeout (`TIMEOUT`>0): a stall counter clears on entry to BUS and increments each edge with `waitrequest`=1. When it reaches `TIMEOUT`, drop the strobe, pulse `resp_valid` with err 10, go to IDLE.
- `read` and `write` are never both 1. Exactly one response is produced per accepted request.

## Timing
- Reset (async, takes effect immediately) returns to IDLE with these values: `read`=0, `write`=0, `address`=0, `byteenable`=0, `writedata`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `req_ready`=1. Reset mid-transfer drops the strobe at once and produces no response.
- Accept at edge E0 → strobe high after E0.
  - Store with zero wait: `resp_valid` high after E1.
  - Load with zero wait: RDATA after E1, `resp_valid` high after E2.
  - Each stall cycle adds 1.
- Misaligned: `resp_valid` high after E1.
- `resp_valid` falls after one cycle. `req_ready` is high in that same cycle, so back-to-back requests have 1 idle-bus cycle minimum.
- `waitrequest` is sampled only in BUS; `readdata` is sampled only in RDATA.

## Test plan
- Word load, addr 0x00000010, memory bytes 10..13 = 78 56 34 12, no wait → `read` for 1 cycle, byteenable 1111, `resp_rdata`=0x12345678 after E2, err 00.
- Signed byte load at 0x13 (byte 0x80), then unsigned → byteenable 1000, `resp_rdata`=0xFFFFFF80, then 0x00000080.
- Half store 0xBEEF at 0x22 with `waitrequest` high for 3 cycles → `write` held 4 cycles with `address`=0x20, byteenable 1100, writedata 0xBEEFBEEF; memory bytes 22/23 = EF/BE; `resp_valid` after E4.
- Word load at 0x06 → no strobe ever; `resp_valid` after E1 with err 01 and rdata 0.
- `TIMEOUT`=4 with `waitrequest` stuck high → `read` drops after 4 stall edges; err 10; next request accepted normally.
- Reset asserted while `write` is stalled → `write`=0 immediately, no `resp_valid`, `req_ready`=1 after reset release.
